// File: rtl/map_table_ckpt_pkg.sv
// Shared configuration, types and CDB helpers for the rename map table and its checkpoint store.
package map_table_ckpt_pkg;

  localparam int ARCH_REGS    = 32;
  localparam int PHYS_REGS    = 64;
  localparam int RENAME_WIDTH = 2;
  localparam int CDB_WIDTH    = 2;
  localparam int RETIRE_WIDTH = 2;
  localparam int NUM_CKPT     = 4;

  localparam int ARCH_W = $clog2(ARCH_REGS);
  localparam int PREG_W = $clog2(PHYS_REGS);
  localparam int CKPT_W = $clog2(NUM_CKPT);
  localparam int CNT_W  = CKPT_W + 1;
  localparam int LANE_W = (RENAME_WIDTH > 1) ? $clog2(RENAME_WIDTH) : 1;

  typedef struct packed {
    logic [PREG_W-1:0] reg_num;
    logic              ready;
  } preg_t;

  typedef preg_t [ARCH_REGS-1:0] mt_snapshot_t;

  typedef logic [CDB_WIDTH-1:0]             cdb_valid_t;
  typedef logic [CDB_WIDTH-1:0][PREG_W-1:0] cdb_pr_t;

  function automatic logic cdb_hit(input logic [PREG_W-1:0] reg_num,
                                   input cdb_valid_t valid, input cdb_pr_t pr);
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < CDB_WIDTH; c++) begin
      if (valid[c] && (pr[c] == reg_num)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Marks every entry whose physical register is being broadcast as ready.
  function automatic mt_snapshot_t cdb_merge(input mt_snapshot_t snap,
                                             input cdb_valid_t valid, input cdb_pr_t pr);
    mt_snapshot_t res;
    res = snap;
    for (int i = 0; i < ARCH_REGS; i++) begin
      if (cdb_hit(snap[i].reg_num, valid, pr)) res[i].ready = 1'b1;
    end
    return res;
  endfunction

  function automatic mt_snapshot_t reset_map();
    mt_snapshot_t res;
    for (int i = 0; i < ARCH_REGS; i++) begin
      res[i] = '{reg_num: PREG_W'(i), ready: 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/map_table_ckpt_ckpt_store.sv
// Circular store of map-table snapshots taken at branches; head is the oldest live slot,
// tail the next slot to allocate. Live snapshots keep tracking CDB readiness.
module map_table_ckpt_ckpt_store
  import map_table_ckpt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_req,
  input  mt_snapshot_t      snap_in,
  input  logic              rel_req,
  input  logic              squash,
  input  logic              flush,
  input  logic [CKPT_W-1:0] br_id,
  input  cdb_valid_t        cdb_valid,
  input  cdb_pr_t           cdb_pr,
  output logic [CKPT_W-1:0] ck_id,
  output logic              ck_full,
  output mt_snapshot_t      restore
);

  logic [CKPT_W-1:0] head_reg, tail_reg;
  logic [CNT_W-1:0]  count_reg;
  mt_snapshot_t      slot_reg [NUM_CKPT];
  logic              alloc, rel;

  // Fullness comes from the registered count, so a same-cycle release cannot enable an allocation.
  assign ck_full = (count_reg == CNT_W'(NUM_CKPT));
  assign ck_id   = tail_reg;
  assign restore = slot_reg[br_id];
  assign alloc   = alloc_req && !ck_full;
  assign rel     = rel_req && (count_reg != '0);

  for (genvar gi = 0; gi < NUM_CKPT; gi++) begin : g_slot
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        slot_reg[gi] <= '0;
      end else if (alloc && (tail_reg == CKPT_W'(gi))) begin
        slot_reg[gi] <= snap_in;
      end else begin
        slot_reg[gi] <= cdb_merge(slot_reg[gi], cdb_valid, cdb_pr);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      head_reg  <= tail_reg;
      count_reg <= '0;
    end else if (squash) begin
      // Keep the resolved branch's slot and everything older; drop the younger ones.
      tail_reg  <= br_id + CKPT_W'(1);
      count_reg <= {1'b0, br_id - head_reg} + CNT_W'(1);
    end else begin
      if (alloc) tail_reg <= tail_reg + CKPT_W'(1);
      if (rel)   head_reg <= head_reg + CKPT_W'(1);
      count_reg <= count_reg + CNT_W'(alloc) - CNT_W'(rel);
    end
  end

  a_release_in_order: assert property (@(posedge clk) disable iff (!reset)
    (rel_req && !flush) |-> (br_id == head_reg));

endmodule

// File: rtl/map_table_ckpt.sv
// Superscalar rename map table with branch checkpoints, retire map and one-cycle recovery.
// Define MAP_TABLE_PERF_CNT_EN to add saturating squash / checkpoint-full / flush counters.
module map_table_ckpt
  import map_table_ckpt_pkg::*;
(
  input  logic                                clk,
  input  logic                                reset,
  input  logic [RENAME_WIDTH-1:0]             rn_valid,
  input  logic [RENAME_WIDTH-1:0][ARCH_W-1:0] rn_rs1,
  input  logic [RENAME_WIDTH-1:0][ARCH_W-1:0] rn_rs2,
  input  logic [RENAME_WIDTH-1:0][ARCH_W-1:0] rn_rd,
  input  logic [RENAME_WIDTH-1:0][PREG_W-1:0] rn_new_pr,
  output preg_t [RENAME_WIDTH-1:0]            rn_src1,
  output preg_t [RENAME_WIDTH-1:0]            rn_src2,
  output preg_t [RENAME_WIDTH-1:0]            rn_old_pr,
  input  cdb_valid_t                          cdb_valid,
  input  cdb_pr_t                             cdb_pr,
  input  logic [RETIRE_WIDTH-1:0]             rt_valid,
  input  logic [RETIRE_WIDTH-1:0][ARCH_W-1:0] rt_rd,
  input  logic [RETIRE_WIDTH-1:0][PREG_W-1:0] rt_pr,
  input  logic                                ck_req,
  input  logic [LANE_W-1:0]                   ck_lane,
  output logic [CKPT_W-1:0]                   ck_id,
  output logic                                ck_full,
  input  logic                                br_valid,
  input  logic                                br_mispred,
  input  logic [CKPT_W-1:0]                   br_id,
  input  logic                                flush,
  output mt_snapshot_t                        map_out,
  output mt_snapshot_t                        arch_out
`ifdef MAP_TABLE_PERF_CNT_EN
  ,
  output logic [31:0]                         perf_squash_cnt,
  output logic [31:0]                         perf_ckfull_cnt,
  output logic [31:0]                         perf_flush_cnt
`endif
);

  localparam preg_t ZERO_PREG = '{reg_num: '0, ready: 1'b1};

  mt_snapshot_t map_reg, arch_reg;
  mt_snapshot_t arch_next, ren_map, ck_snap, restore_snap;
  logic         squash, rel_req, alloc_req;

  assign squash    = br_valid && br_mispred && !flush;
  assign rel_req   = br_valid && !br_mispred && !flush;
  assign alloc_req = ck_req && !flush && !(br_valid && br_mispred);

  // Source/old-dest lookup: map entry (CDB-forwarded for sources), overridden by the youngest older lane.
  always_comb begin
    for (int j = 0; j < RENAME_WIDTH; j++) begin
      rn_src1[j]       = map_reg[rn_rs1[j]];
      rn_src1[j].ready = rn_src1[j].ready | cdb_hit(rn_src1[j].reg_num, cdb_valid, cdb_pr);
      rn_src2[j]       = map_reg[rn_rs2[j]];
      rn_src2[j].ready = rn_src2[j].ready | cdb_hit(rn_src2[j].reg_num, cdb_valid, cdb_pr);
      rn_old_pr[j]     = map_reg[rn_rd[j]];
      for (int k = 0; k < j; k++) begin
        if (rn_valid[k]) begin
          if (rn_rd[k] == rn_rs1[j]) rn_src1[j]   = '{reg_num: rn_new_pr[k], ready: 1'b0};
          if (rn_rd[k] == rn_rs2[j]) rn_src2[j]   = '{reg_num: rn_new_pr[k], ready: 1'b0};
          if (rn_rd[k] == rn_rd[j])  rn_old_pr[j] = '{reg_num: rn_new_pr[k], ready: 1'b0};
        end
      end
      if (rn_rs1[j] == '0) rn_src1[j]   = ZERO_PREG;
      if (rn_rs2[j] == '0) rn_src2[j]   = ZERO_PREG;
      if (rn_rd[j] == '0)  rn_old_pr[j] = ZERO_PREG;
    end
  end

  // Rename writes are applied after the CDB so a same-cycle rename leaves the entry not ready.
  always_comb begin
    ren_map = cdb_merge(map_reg, cdb_valid, cdb_pr);
    ck_snap = ren_map;
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      if (rn_valid[k] && (rn_rd[k] != '0)) begin
        ren_map[rn_rd[k]] = '{reg_num: rn_new_pr[k], ready: 1'b0};
      end
      if (LANE_W'(k) == ck_lane) ck_snap = ren_map;
    end
  end

  always_comb begin
    arch_next = arch_reg;
    for (int r = 0; r < RETIRE_WIDTH; r++) begin
      if (rt_valid[r] && (rt_rd[r] != '0)) begin
        arch_next[rt_rd[r]] = '{reg_num: rt_pr[r], ready: 1'b1};
      end
    end
    arch_next = cdb_merge(arch_next, cdb_valid, cdb_pr);
  end

  map_table_ckpt_ckpt_store u_store (
    .clk       (clk),
    .reset     (reset),
    .alloc_req (alloc_req),
    .snap_in   (ck_snap),
    .rel_req   (rel_req),
    .squash    (squash),
    .flush     (flush),
    .br_id     (br_id),
    .cdb_valid (cdb_valid),
    .cdb_pr    (cdb_pr),
    .ck_id     (ck_id),
    .ck_full   (ck_full),
    .restore   (restore_snap)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      map_reg  <= reset_map();
      arch_reg <= reset_map();
    end else begin
      arch_reg <= arch_next;
      if (flush) begin
        map_reg <= arch_next;
      end else if (squash) begin
        map_reg <= cdb_merge(restore_snap, cdb_valid, cdb_pr);
      end else begin
        map_reg <= ren_map;
      end
    end
  end

  assign map_out  = map_reg;
  assign arch_out = arch_reg;

`ifdef MAP_TABLE_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_squash_cnt <= '0;
      perf_ckfull_cnt <= '0;
      perf_flush_cnt  <= '0;
    end else begin
      if (squash && (perf_squash_cnt != '1))             perf_squash_cnt <= perf_squash_cnt + 32'd1;
      if (ck_req && ck_full && (perf_ckfull_cnt != '1))  perf_ckfull_cnt <= perf_ckfull_cnt + 32'd1;
      if (flush && (perf_flush_cnt != '1))               perf_flush_cnt  <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_map_table_ckpt.sv
// Directed plus randomized bench for map_table_ckpt against a queue-based reference model.
module tb_map_table_ckpt;
  import map_table_ckpt_pkg::*;

  typedef logic [ARCH_REGS-1:0][PREG_W:0] snap_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [RENAME_WIDTH-1:0]             rn_valid;
  logic [RENAME_WIDTH-1:0][ARCH_W-1:0] rn_rs1, rn_rs2, rn_rd;
  logic [RENAME_WIDTH-1:0][PREG_W-1:0] rn_new_pr;
  preg_t [RENAME_WIDTH-1:0]            rn_src1, rn_src2, rn_old_pr;
  cdb_valid_t                          cdb_valid;
  cdb_pr_t                             cdb_pr;
  logic [RETIRE_WIDTH-1:0]             rt_valid;
  logic [RETIRE_WIDTH-1:0][ARCH_W-1:0] rt_rd;
  logic [RETIRE_WIDTH-1:0][PREG_W-1:0] rt_pr;
  logic                                ck_req;
  logic [LANE_W-1:0]                   ck_lane;
  logic [CKPT_W-1:0]                   ck_id;
  logic                                ck_full;
  logic                                br_valid, br_mispred;
  logic [CKPT_W-1:0]                   br_id;
  logic                                flush;
  mt_snapshot_t                        map_out, arch_out;
`ifdef MAP_TABLE_PERF_CNT_EN
  logic [31:0] perf_squash_cnt, perf_ckfull_cnt, perf_flush_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  snap_t m_map, m_arch;
  snap_t q_snap[$];
  int    q_id[$];
  int    m_tail;

  map_table_ckpt dut (
    .clk(clk), .reset(reset),
    .rn_valid(rn_valid), .rn_rs1(rn_rs1), .rn_rs2(rn_rs2), .rn_rd(rn_rd), .rn_new_pr(rn_new_pr),
    .rn_src1(rn_src1), .rn_src2(rn_src2), .rn_old_pr(rn_old_pr),
    .cdb_valid(cdb_valid), .cdb_pr(cdb_pr),
    .rt_valid(rt_valid), .rt_rd(rt_rd), .rt_pr(rt_pr),
    .ck_req(ck_req), .ck_lane(ck_lane), .ck_id(ck_id), .ck_full(ck_full),
    .br_valid(br_valid), .br_mispred(br_mispred), .br_id(br_id), .flush(flush),
    .map_out(map_out), .arch_out(arch_out)
`ifdef MAP_TABLE_PERF_CNT_EN
    , .perf_squash_cnt(perf_squash_cnt), .perf_ckfull_cnt(perf_ckfull_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_snap(input string tag, input snap_t got, input snap_t exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PREG_W:0] mk(input int pr, input bit rdy);
    return {PREG_W'(pr), rdy};
  endfunction

  function automatic snap_t reset_snap();
    snap_t s;
    for (int i = 0; i < ARCH_REGS; i++) s[i] = mk(i, 1'b1);
    return s;
  endfunction

  function automatic snap_t apply_cdb(input snap_t s);
    snap_t r = s;
    for (int i = 0; i < ARCH_REGS; i++)
      for (int c = 0; c < CDB_WIDTH; c++)
        if (cdb_valid[c] && cdb_pr[c] == s[i][PREG_W:1]) r[i][0] = 1'b1;
    return r;
  endfunction

  // Renames of lanes 0..last written into a map, later lanes overriding earlier ones.
  function automatic snap_t apply_lanes(input snap_t s, input int last);
    snap_t r = s;
    for (int k = 0; k <= last; k++)
      if (rn_valid[k] && rn_rd[k] != '0) r[rn_rd[k]] = {rn_new_pr[k], 1'b0};
    return r;
  endfunction

  function automatic logic [PREG_W:0] exp_src(input int j, input int idx, input bit fwd);
    logic [PREG_W:0] e;
    if (idx == 0) return mk(0, 1'b1);
    for (int k = j - 1; k >= 0; k--)
      if (rn_valid[k] && int'(rn_rd[k]) == idx) return {rn_new_pr[k], 1'b0};
    e = m_map[idx];
    if (fwd)
      for (int c = 0; c < CDB_WIDTH; c++)
        if (cdb_valid[c] && cdb_pr[c] == e[PREG_W:1]) e[0] = 1'b1;
    return e;
  endfunction

  task automatic model_reset();
    m_map = reset_snap();
    m_arch = reset_snap();
    q_snap.delete();
    q_id.delete();
    m_tail = 0;
  endtask

  task automatic model_next();
    snap_t na = m_arch;
    for (int r = 0; r < RETIRE_WIDTH; r++)
      if (rt_valid[r] && rt_rd[r] != '0) na[rt_rd[r]] = {rt_pr[r], 1'b1};
    na = apply_cdb(na);
    if (flush) begin
      m_map = na;
      q_snap.delete();
      q_id.delete();
    end else if (br_valid && br_mispred) begin
      int pos = -1;
      foreach (q_id[i]) if (q_id[i] == int'(br_id)) pos = i;
      if (pos < 0) pos = 0;
      m_map = apply_cdb(q_snap[pos]);
      while (q_id.size() > pos + 1) begin
        void'(q_id.pop_back());
        void'(q_snap.pop_back());
      end
      foreach (q_snap[i]) q_snap[i] = apply_cdb(q_snap[i]);
      m_tail = (int'(br_id) + 1) % NUM_CKPT;
    end else begin
      bit    was_full = (q_id.size() == NUM_CKPT);
      snap_t base = apply_cdb(m_map);
      foreach (q_snap[i]) q_snap[i] = apply_cdb(q_snap[i]);
      if (br_valid && q_id.size() > 0) begin
        void'(q_id.pop_front());
        void'(q_snap.pop_front());
      end
      if (ck_req && !was_full) begin
        q_id.push_back(m_tail);
        q_snap.push_back(apply_lanes(base, int'(ck_lane)));
        m_tail = (m_tail + 1) % NUM_CKPT;
      end
      m_map = apply_lanes(base, RENAME_WIDTH - 1);
    end
    m_arch = na;
  endtask

  task automatic idle();
    rn_valid = '0; rn_rs1 = '0; rn_rs2 = '0; rn_rd = '0; rn_new_pr = '0;
    cdb_valid = '0; cdb_pr = '0;
    rt_valid = '0; rt_rd = '0; rt_pr = '0;
    ck_req = 1'b0; ck_lane = '0;
    br_valid = 1'b0; br_mispred = 1'b0; br_id = '0; flush = 1'b0;
  endtask

  // One transaction: combinational outputs checked mid-cycle, state checked after the edge.
  task automatic step();
    #1;
    for (int j = 0; j < RENAME_WIDTH; j++) begin
      chk("rn_src1", 32'(rn_src1[j]), 32'(exp_src(j, int'(rn_rs1[j]), 1'b1)));
      chk("rn_src2", 32'(rn_src2[j]), 32'(exp_src(j, int'(rn_rs2[j]), 1'b1)));
      chk("rn_old_pr", 32'(rn_old_pr[j]), 32'(exp_src(j, int'(rn_rd[j]), 1'b0)));
    end
    chk("ck_id", 32'(ck_id), 32'(m_tail));
    chk("ck_full", 32'(ck_full), 32'(q_id.size() == NUM_CKPT));
    model_next();
    @(posedge clk);
    #1;
    chk_snap("map_out", map_out, m_map);
    chk_snap("arch_out", arch_out, m_arch);
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    chk_snap({tag, "_map"}, map_out, reset_snap());
    chk_snap({tag, "_arch"}, arch_out, reset_snap());
    chk({tag, "_ck_full"}, 32'(ck_full), 32'd0);
    chk({tag, "_ck_id"}, 32'(ck_id), 32'd0);
`ifdef MAP_TABLE_PERF_CNT_EN
    chk({tag, "_perf_squash"}, perf_squash_cnt, 32'd0);
    chk({tag, "_perf_ckfull"}, perf_ckfull_cnt, 32'd0);
    chk({tag, "_perf_flush"}, perf_flush_cnt, 32'd0);
`endif
  endtask

  initial begin
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset("reset");
    chk("reset_map5", 32'(map_out[5]), 32'(mk(5, 1'b1)));

    // Intra-group bypass of a fresh destination.
    idle();
    rn_valid = 2'b11; rn_rd[0] = 5; rn_new_pr[0] = 40; rn_rs1[1] = 5;
    #1;
    chk("t1_src1_lane1", 32'(rn_src1[1]), 32'(mk(40, 1'b0)));
    chk("t1_old_lane0", 32'(rn_old_pr[0]), 32'(mk(5, 1'b1)));
    step();

    // CDB forwarding on the read and into the map.
    idle();
    rn_valid = 2'b01; rn_rd[0] = 3; rn_new_pr[0] = 33;
    step();
    idle();
    rn_rs1[0] = 3; cdb_valid = 2'b10; cdb_pr[1] = 33;
    #1;
    chk("t2_src1_fwd", 32'(rn_src1[0]), 32'(mk(33, 1'b1)));
    step();
    chk("t2_map3_ready", 32'(map_out[3]), 32'(mk(33, 1'b1)));

    // Checkpoint after lane 0, then squash back to it.
    idle();
    ck_req = 1'b1; ck_lane = 0; rn_valid = 2'b11;
    rn_rd[0] = 7; rn_new_pr[0] = 41; rn_rd[1] = 8; rn_new_pr[1] = 42;
    #1;
    chk("t3_ck_id", 32'(ck_id), 32'd0);
    step();
    idle();
    br_valid = 1'b1; br_mispred = 1'b1; br_id = 0;
    step();
    chk("t3_map7", 32'(map_out[7].reg_num), 32'd41);
    chk("t3_map8", 32'(map_out[8]), 32'(mk(8, 1'b1)));

    // Release slot 0, fill all four slots, then try allocating while full.
    idle();
    br_valid = 1'b1; br_id = 0;
    step();
    for (int n = 0; n < NUM_CKPT; n++) begin
      idle();
      ck_req = 1'b1;
      step();
    end
    chk("t4_full", 32'(ck_full), 32'd1);
    idle();
    ck_req = 1'b1;
    step();
    chk("t4_ck_id_held", 32'(ck_id), 32'd1);
    idle();
    ck_req = 1'b1; br_valid = 1'b1; br_id = 1;
    step();
    chk("t4_rel_no_alloc_full", 32'(ck_full), 32'd0);
    chk("t4_rel_no_alloc_id", 32'(ck_id), 32'd1);

    // Same-cycle retires to one register, then flush from the architectural map.
    idle();
    rt_valid = 2'b11; rt_rd[0] = 9; rt_pr[0] = 50; rt_rd[1] = 9; rt_pr[1] = 51;
    step();
    chk("t5_arch9", 32'(arch_out[9]), 32'(mk(51, 1'b1)));
    idle();
    flush = 1'b1;
    step();
    chk("t5_map9", 32'(map_out[9]), 32'(mk(51, 1'b1)));
    chk("t5_full_clear", 32'(ck_full), 32'd0);

    for (int n = 0; n < 400; n++) begin
      idle();
      for (int j = 0; j < RENAME_WIDTH; j++) begin
        rn_valid[j]  = 1'($urandom_range(0, 1));
        rn_rs1[j]    = ARCH_W'($urandom_range(0, 7));
        rn_rs2[j]    = ARCH_W'($urandom_range(0, 7));
        rn_rd[j]     = ARCH_W'($urandom_range(0, 7));
        rn_new_pr[j] = PREG_W'($urandom_range(32, 63));
      end
      for (int c = 0; c < CDB_WIDTH; c++) begin
        cdb_valid[c] = 1'($urandom_range(0, 1));
        cdb_pr[c]    = m_map[$urandom_range(0, 7)][PREG_W:1];
      end
      for (int r = 0; r < RETIRE_WIDTH; r++) begin
        rt_valid[r] = 1'($urandom_range(0, 1));
        rt_rd[r]    = ARCH_W'($urandom_range(0, 7));
        rt_pr[r]    = PREG_W'($urandom_range(32, 63));
      end
      ck_req  = ($urandom_range(0, 2) == 0);
      ck_lane = LANE_W'($urandom_range(0, RENAME_WIDTH - 1));
      if (q_id.size() > 0 && $urandom_range(0, 3) == 0) begin
        br_valid   = 1'b1;
        br_mispred = ($urandom_range(0, 2) == 0);
        br_id = br_mispred ? CKPT_W'(q_id[$urandom_range(0, q_id.size() - 1)]) : CKPT_W'(q_id[0]);
      end
      flush = ($urandom_range(0, 29) == 0);
      step();
    end

    // Asynchronous reset in the middle of a squash cycle.
    idle();
    flush = 1'b1;
    step();
    idle();
    ck_req = 1'b1;
    step();
    idle();
    br_valid = 1'b1; br_mispred = 1'b1; br_id = CKPT_W'(q_id[0]);
    rn_valid = 2'b11; rn_rd[0] = 4; rn_new_pr[0] = 60;
    #2;
    reset = 1'b0;
    #1;
    check_reset("async_reset");
    @(negedge clk);
    idle();
    reset = 1'b1;
    model_reset();
    #1;
    check_reset("after_reset");
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
